// File: rtl/cla_issue_ctrl.sv
// cla_issue_ctrl
// Credit-based flow-control wrapper around a fixed-latency pipelined 32-bit
// CLA adder. Operand pairs arrive over a valid/ready handshake and go
// straight to the adder inputs. A one-hot-per-cycle valid tag travels beside
// the adder pipeline. When the tag reaches the end, the adder output is
// written into a small result FIFO. The downstream consumer drains that FIFO
// with its own valid/ready handshake. The adder cannot stall, so a new pair
// is only admitted when a FIFO slot is guaranteed for its result.
//
// Handshake semantics, for both ports:
//   A transfer happens on a rising edge where valid and ready are both high.
//   The source holds data and valid stable until the transfer. Ready may
//   change at any time and never depends combinationally on the valid of the
//   same port. Once m_valid is high, it stays high with m_sum stable until popped.
//
// Ports
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   s_valid/s_ready        operand handshake; s_a, s_b are the operands
//   add_in1/add_in2        to the adder; these are s_a/s_b passed through
//   add_out                adder result, ADD_LATENCY cycles after its inputs
//   m_valid/m_ready        result handshake; m_sum is the FIFO head
//   o_idle                 nothing in flight and the FIFO is empty
module cla_issue_ctrl #(
  parameter int ADD_LATENCY = 7,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_a,
  input  logic [31:0] s_b,
  output logic [31:0] add_in1,
  output logic [31:0] add_in2,
  input  logic [32:0] add_out,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [32:0] m_sum,
  output logic        o_idle
);

  localparam int IW = $clog2(ADD_LATENCY + 1);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = ((IW > OW) ? IW : OW) + 1;

  if (ADD_LATENCY < 1) begin : g_bad_lat
    $error("ADD_LATENCY must be at least 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  logic [ADD_LATENCY-1:0] tag_q, tag_d;
  logic [IW-1:0]          inflight_q, inflight_d;
  logic [OW-1:0]          occ_q, occ_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [32:0]            mem_q [FIFO_DEPTH];

  logic          issue;
  logic          capture;
  logic          pop;
  logic [CW-1:0] credit_used;

  assign add_in1 = s_a;
  assign add_in2 = s_b;

  // Credits come from registered counts only, so m_ready never reaches
  // s_ready within a cycle; a pop frees its slot from the next cycle on.
  assign credit_used = CW'(occ_q) + CW'(inflight_q);
  assign s_ready     = i_rst_n & (credit_used < CW'(FIFO_DEPTH));

  assign issue   = s_valid & s_ready;
  assign capture = tag_q[ADD_LATENCY-1];
  assign m_valid = (occ_q != '0);
  assign pop     = m_valid & m_ready;
  assign m_sum   = mem_q[rd_ptr_q];
  assign o_idle  = (inflight_q == '0) & (occ_q == '0);

  always_comb begin
    tag_d    = tag_q << 1;
    tag_d[0] = issue;

    inflight_d = inflight_q;
    case ({issue, capture})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase

    occ_d = occ_q;
    case ({capture, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase

    // Power-of-two depth: the pointers wrap by natural overflow.
    wr_ptr_d = capture ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag_q      <= '0;
      inflight_q <= '0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Result storage is not reset; only entries between the pointers are read.
  // Stale adder outputs after reset are never written since all tags clear.
  always_ff @(posedge i_clk) begin
    if (capture) begin
      mem_q[wr_ptr_q] <= add_out;
    end
  end

  // Credit admission makes a capture into a full FIFO unreachable.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(capture && (occ_q == OW'(FIFO_DEPTH))));

endmodule
